fpnew_slice_result_fifo: RTL
============================

// Module: fpnew_slice_result_fifo
// PURPOSE
// - Output buffer directly downstream of a format slice (one opgroup, one format). Captures
//   {result, status, extension bit, tag} on each accepted slice output and replays it in
//   order to the opgroup output arbiter.
// - Decouples arbiter backpressure from the slice pipeline: in_ready_o has no combinational
//   path from out_ready_i. busy_o lets the FPU top gate clocks and the flush logic.
// PARAMETERS
// - Width    32     data width of result_i/result_o; equals the slice Width
// - Depth    2      number of entries; any integer >= 1, not restricted to powers of two
// - TagType  logic  opaque tag type carried alongside each result
// - CntWidth $clog2(Depth+1)  localparam; width of count_o
// PORTS
// - clk_i              in   1          clock, rising edge
// - rst_i              in   1          asynchronous reset, active-high
// - result_i           in   Width      slice result
// - status_i           in   5          fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
// - extension_bit_i    in   1          slice extension bit (NaN-box / sign-extend)
// - tag_i              in   TagType    slice tag
// - in_valid_i         in   1          slice output valid
// - in_ready_o         out  1          buffer can accept; drives slice out_ready_i
// - flush_i            in   1          discard all stored entries
// - result_o           out  Width      head entry result
// - status_o           out  5          head entry status
// - extension_bit_o    out  1          head entry extension bit
// - tag_o              out  TagType    head entry tag
// - out_valid_o        out  1          head entry valid
// - out_ready_i        in   1          arbiter accepts head entry
// - count_o            out  CntWidth   number of stored entries
// - busy_o             out  1          entries stored or input pending
// BEHAVIOUR
// - Storage: circular buffer with Depth entries, write pointer wr_ptr, read pointer rd_ptr,
//   and occupancy count. Each pointer increments modulo Depth: Depth-1 wraps to 0.
// - push = in_valid_i & in_ready_o & ~flush_i;  pop = out_valid_o & out_ready_i & ~flush_i.
// - in_ready_o = (count < Depth). This depends only on registered state.
// - out_valid_o = (count != 0). There is no fall-through path: a push at edge N is visible
//   at the output after edge N, so minimum latency is 1 cycle.
// - Head outputs come from entry rd_ptr. When count == 0 they hold the last-read or reset
//   contents; consumers must qualify them with out_valid_o.
// - Push and pop in the same cycle with 0 < count < Depth: both pointers advance and count
//   is unchanged.
// - When full (count == Depth), in_ready_o = 0. A pop that cycle does not enable a
//   same-cycle push; in_ready_o rises on the following cycle.
// - When empty, pop is impossible because out_valid_o = 0. A push raises count to 1.
// - Flush: at the next edge, count, wr_ptr and rd_ptr all return to 0 and storage is left
//   untouched. Any push or pop in the flush cycle is ignored. Flush has priority over both.
// - Entries are stored verbatim; status and data are never merged across entries.
// - busy_o = (count != 0) | in_valid_i.
// - Reset (asynchronous, takes effect immediately when rst_i rises):
//   - count, wr_ptr, rd_ptr = 0; all storage = 0.
//   - Hence out_valid_o = 0, in_ready_o = 1, result_o = 0, status_o = 0,
//     extension_bit_o = 0, tag_o = '0, count_o = 0, and busy_o = in_valid_i.
//   - Reset mid-transfer drops all entries. No handshake completes while rst_i is high.
// - Assertions (simulation only):
//   - count <= Depth.
//   - While out_valid_o & ~out_ready_i & ~flush_i, the head payload is stable.
// TESTING
// - Reset, then push result 0x3F800000 with tag 1 -> out_valid_o rises 1 cycle later with
//   result_o = 0x3F800000, tag_o = 1, count_o = 1.
// - Depth=2, out_ready_i=0, push 3 back-to-back -> in_ready_o = 0 after the 2nd push; the 3rd
//   is held by the slice; count_o = 2.
// - Depth=3 steady streaming with in/out always ready for 10 items -> in-order delivery,
//   1 item per cycle, pointers wrap 2->0 with no loss or duplication.
// - Full buffer, pop one -> in_ready_o = 0 that cycle and 1 on the next; the next push lands
//   in the freed slot and order is preserved.
// - count = 2, assert flush_i together with in_valid_i and out_ready_i -> count_o = 0 next
//   cycle, out_valid_o = 0, no item is delivered or accepted.
// - Raise rst_i asynchronously mid-stream -> out_valid_o = 0 and in_ready_o = 1 immediately.
//   After release, a push of status 5'b00001 gives status_o = 5'b00001.

Source files
------------

// File: rtl/fpnew_slice_result_fifo.sv
// Output buffer behind one format slice: stores {result, status, extension bit, tag}
// in a circular buffer and replays the entries in order to the opgroup arbiter.
module fpnew_slice_result_fifo #(
    parameter int unsigned Width    = 32,
    parameter int unsigned Depth    = 2,
    parameter type         TagType  = logic,
    localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Width-1:0]    result_i,
    input  logic [4:0]          status_i,
    input  logic                extension_bit_i,
    input  TagType              tag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    output logic [Width-1:0]    result_o,
    output logic [4:0]          status_o,
    output logic                extension_bit_o,
    output TagType              tag_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CntWidth-1:0] count_o,
    output logic                busy_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    typedef struct packed {
        logic [Width-1:0] result;
        logic [4:0]       status;
        logic             extension_bit;
        TagType           tag;
    } entry_t;

    entry_t                entry_mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CntWidth-1:0]   count_reg, count_next;
    logic                  push;
    logic                  pop;
    entry_t                head;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(Depth - 1)) begin
            return '0;
        end
        return ptr + PtrWidth'(1);
    endfunction

    // Ready and valid come from registered count only, so out_ready_i never reaches in_ready_o.
    assign in_ready_o  = (count_reg < CntWidth'(Depth));
    assign out_valid_o = (count_reg != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            if (push && !pop) begin
                count_next = count_reg + CntWidth'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is cleared on reset so the head outputs read as zero until the first push.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                entry_mem[i] <= '0;
            end
        end else if (push) begin
            entry_mem[wr_ptr_reg] <= '{result:        result_i,
                                       status:        status_i,
                                       extension_bit: extension_bit_i,
                                       tag:           tag_i};
        end
    end

    assign head            = entry_mem[rd_ptr_reg];
    assign result_o        = head.result;
    assign status_o        = head.status;
    assign extension_bit_o = head.extension_bit;
    assign tag_o           = head.tag;
    assign count_o         = count_reg;
    assign busy_o          = out_valid_o | in_valid_i;

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_reg <= CntWidth'(Depth))
        else $error("fifo occupancy exceeds depth");

    a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i && !flush_i) |=> $stable(head))
        else $error("head payload changed while stalled");

endmodule
